// File: rtl/input_selector_pipe.sv
// input_selector_pipe
// Registered lane router. Each lane takes one main input or one register input,
// chosen by an internally held routing table. The output buses share a single
// capture, but each bus drains through its own valid/ready handshake. The block
// also counts accepted beats and raises a sticky flag for out-of-range selections.
module input_selector_pipe #(
    parameter int DATA_WIDTH      = 4,
    parameter int MAIN_INPUTS     = 16,
    parameter int REGS_INPUTS     = 64,
    parameter int OUTPUTS         = 4,
    parameter int OUTPUTS_PER_BUS = 4,
    parameter int COUNT_WIDTH     = 16,
    localparam int MS             = $clog2(MAIN_INPUTS),
    localparam int RS             = $clog2(REGS_INPUTS),
    localparam int SEL_W          = 1 + MS + RS,
    localparam int LANES          = OUTPUTS * OUTPUTS_PER_BUS
) (
    input  logic                               clk,
    input  logic                               reset_L,
    input  logic                               wBusy,
    input  logic                               wSelecLoad,
    input  logic [LANES*SEL_W-1:0]             wSelec,
    input  logic                               wDataValid,
    input  logic [MAIN_INPUTS*DATA_WIDTH-1:0]  wData,
    input  logic [REGS_INPUTS*DATA_WIDTH-1:0]  wRegs,
    input  logic [OUTPUTS-1:0]                 wReady,
    output logic                               wDataReady,
    output logic [LANES*DATA_WIDTH-1:0]        r,
    output logic [OUTPUTS-1:0]                 rValid,
    output logic                               wSelErr,
    output logic [COUNT_WIDTH-1:0]             wCount
);

    // Index limits, widened by one bit so that the power-of-two case compares cleanly.
    localparam logic [MS:0] MAIN_LIM = (MS+1)'(MAIN_INPUTS);
    localparam logic [RS:0] REGS_LIM = (RS+1)'(REGS_INPUTS);

    logic [LANES*SEL_W-1:0]      sel_tbl;
    logic [LANES*DATA_WIDTH-1:0] cap_data;
    logic                        cap_err;
    logic                        accept;
    logic                        buses_free;
    logic                        lane_org;
    logic [MS-1:0]               lane_midx;
    logic [RS-1:0]               lane_ridx;

    // Each bus must be either empty or handing off its beat during this cycle.
    assign buses_free = &(~rValid | wReady);
    assign wDataReady = !wBusy && buses_free;
    assign accept     = wDataValid && wDataReady;

    // Resolve every lane against the active table. Out-of-range lanes capture zero.
    always_comb begin
        cap_data  = '0;
        cap_err   = 1'b0;
        lane_org  = 1'b0;
        lane_midx = '0;
        lane_ridx = '0;
        for (int k = 0; k < LANES; k++) begin
            lane_org  = sel_tbl[k*SEL_W];
            lane_midx = sel_tbl[k*SEL_W+1 +: MS];
            lane_ridx = sel_tbl[k*SEL_W+1+MS +: RS];
            if (!lane_org) begin
                if ({1'b0, lane_midx} >= MAIN_LIM)
                    cap_err = 1'b1;
                else
                    cap_data[k*DATA_WIDTH +: DATA_WIDTH] =
                        wData[int'(lane_midx)*DATA_WIDTH +: DATA_WIDTH];
            end else begin
                if ({1'b0, lane_ridx} >= REGS_LIM)
                    cap_err = 1'b1;
                else
                    cap_data[k*DATA_WIDTH +: DATA_WIDTH] =
                        wRegs[int'(lane_ridx)*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    // Routing table. A capture in the load cycle still sees the old contents.
    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L)
            sel_tbl <= '0;
        else if (wSelecLoad)
            sel_tbl <= wSelec;
    end

    // Output lanes and per-bus valids. Lanes hold their value until the next accept.
    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            r      <= '0;
            rValid <= '0;
        end else if (accept) begin
            r      <= cap_data;
            rValid <= '1;
        end else begin
            rValid <= rValid & ~wReady;
        end
    end

    // Accepted beat counter, wrapping naturally at its width.
    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L)
            wCount <= '0;
        else if (accept)
            wCount <= wCount + COUNT_WIDTH'(1);
    end

    // Sticky selection error. Setting on an erroring accept wins over a clear by table load.
    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L)
            wSelErr <= 1'b0;
        else if (accept && cap_err)
            wSelErr <= 1'b1;
        else if (wSelecLoad)
            wSelErr <= 1'b0;
    end

endmodule

// File: tb/tb_input_selector_pipe.sv
// Bench for input_selector_pipe, built with 12 main inputs (so that out-of-range
// main indices exist) and a 4-bit counter (so that wrap is reached quickly).
module tb_input_selector_pipe;

    localparam int DW    = 4;
    localparam int MI    = 12;
    localparam int RI    = 64;
    localparam int NO    = 4;
    localparam int OPB   = 4;
    localparam int CW    = 4;
    localparam int MS    = 4;
    localparam int RS    = 6;
    localparam int SEL_W = 1 + MS + RS;
    localparam int LANES = NO * OPB;

    logic                   clk = 1'b0;
    logic                   reset_L;
    logic                   wBusy;
    logic                   wSelecLoad;
    logic [LANES*SEL_W-1:0] wSelec;
    logic                   wDataValid;
    logic [MI*DW-1:0]       wData;
    logic [RI*DW-1:0]       wRegs;
    logic [NO-1:0]          wReady;
    logic                   wDataReady;
    logic [LANES*DW-1:0]    r;
    logic [NO-1:0]          rValid;
    logic                   wSelErr;
    logic [CW-1:0]          wCount;

    always #5 clk = ~clk;

    input_selector_pipe #(
        .DATA_WIDTH(DW), .MAIN_INPUTS(MI), .REGS_INPUTS(RI),
        .OUTPUTS(NO), .OUTPUTS_PER_BUS(OPB), .COUNT_WIDTH(CW)
    ) dut (
        .clk(clk), .reset_L(reset_L), .wBusy(wBusy), .wSelecLoad(wSelecLoad),
        .wSelec(wSelec), .wDataValid(wDataValid), .wData(wData), .wRegs(wRegs),
        .wReady(wReady), .wDataReady(wDataReady), .r(r), .rValid(rValid),
        .wSelErr(wSelErr), .wCount(wCount)
    );

    int vectors     = 0;
    int miscompares = 0;

    // Stimulus-side view of the inputs
    int main_in [MI];
    int regs_in [RI];
    int new_org [LANES];
    int new_idx [LANES];
    int new_junk[LANES];

    // Reference model state
    int act_org [LANES];
    int act_idx [LANES];
    bit m_valid [NO];
    int m_r     [LANES];
    int m_count;
    bit m_err;
    int bus_q   [NO][$];

    function automatic void drive_vectors();
        int f;
        for (int i = 0; i < MI; i++) wData[i*DW +: DW] = DW'(main_in[i]);
        for (int i = 0; i < RI; i++) wRegs[i*DW +: DW] = DW'(regs_in[i]);
        for (int k = 0; k < LANES; k++) begin
            if (new_org[k] == 0)
                f = ((new_idx[k] & 15) << 1) | ((new_junk[k] & 63) << 5);
            else
                f = 1 | ((new_junk[k] & 15) << 1) | ((new_idx[k] & 63) << 5);
            wSelec[k*SEL_W +: SEL_W] = SEL_W'(f);
        end
    endfunction

    function automatic void random_data();
        for (int i = 0; i < MI; i++) main_in[i] = int'($urandom_range(0, 15));
        for (int i = 0; i < RI; i++) regs_in[i] = int'($urandom_range(0, 15));
    endfunction

    function automatic void random_table();
        for (int k = 0; k < LANES; k++) begin
            new_org[k]  = int'($urandom_range(0, 1));
            new_idx[k]  = (new_org[k] == 0) ? int'($urandom_range(0, 15)) : int'($urandom_range(0, 63));
            new_junk[k] = int'($urandom_range(0, 63));
        end
    endfunction

    function automatic void model_reset();
        for (int k = 0; k < LANES; k++) begin
            act_org[k] = 0;
            act_idx[k] = 0;
            m_r[k]     = 0;
        end
        for (int b = 0; b < NO; b++) begin
            m_valid[b] = 1'b0;
            bus_q[b].delete();
        end
        m_count = 0;
        m_err   = 1'b0;
    endfunction

    // One clock edge of the reference behaviour, using the inputs the bench is applying.
    function automatic void model_edge();
        bit rdy;
        bit acc;
        bit e;
        int entry;
        if (!reset_L) begin
            model_reset();
            return;
        end
        rdy = !wBusy;
        for (int b = 0; b < NO; b++)
            if (m_valid[b] && !wReady[b]) rdy = 1'b0;
        acc = wDataValid && rdy;
        if (acc) begin
            e = 1'b0;
            for (int k = 0; k < LANES; k++) begin
                if (act_org[k] == 0) begin
                    if (act_idx[k] < MI) m_r[k] = main_in[act_idx[k]];
                    else begin m_r[k] = 0; e = 1'b1; end
                end else begin
                    if (act_idx[k] < RI) m_r[k] = regs_in[act_idx[k]];
                    else begin m_r[k] = 0; e = 1'b1; end
                end
            end
            for (int b = 0; b < NO; b++) begin
                entry = 0;
                for (int j = 0; j < OPB; j++) entry |= m_r[b*OPB+j] << (j*DW);
                bus_q[b].push_back(entry);
                m_valid[b] = 1'b1;
            end
            m_count = (m_count + 1) % (1 << CW);
            if (e) m_err = 1'b1;
            else if (wSelecLoad) m_err = 1'b0;
        end else begin
            for (int b = 0; b < NO; b++)
                if (m_valid[b] && wReady[b]) m_valid[b] = 1'b0;
            if (wSelecLoad) m_err = 1'b0;
        end
        if (wSelecLoad)
            for (int k = 0; k < LANES; k++) begin
                act_org[k] = new_org[k];
                act_idx[k] = new_idx[k];
            end
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    // Monitor: compares state every cycle and pops a bus beat whenever that bus hands off.
    initial begin
        logic [63:0] exp_r;
        logic [NO-1:0] exp_v;
        bit exp_rdy;
        int entry;
        forever begin
            @(negedge clk);
            exp_r = '0;
            for (int k = 0; k < LANES; k++) exp_r[k*DW +: DW] = DW'(m_r[k]);
            exp_rdy = !wBusy;
            for (int b = 0; b < NO; b++) begin
                exp_v[b] = m_valid[b];
                if (m_valid[b] && !wReady[b]) exp_rdy = 1'b0;
            end
            chk("r", 64'(r), exp_r);
            chk("rValid", 64'(rValid), 64'(exp_v));
            chk("wDataReady", 64'(wDataReady), 64'(exp_rdy));
            chk("wCount", 64'(wCount), 64'(m_count));
            chk("wSelErr", 64'(wSelErr), 64'(m_err));
            for (int b = 0; b < NO; b++) begin
                if (reset_L && rValid[b] && wReady[b]) begin
                    if (bus_q[b].size() == 0) begin
                        vectors++;
                        miscompares++;
                        $display("FAIL bus%0d_beat at %0t: got handoff, expected no pending beat", b, $time);
                    end else begin
                        entry = bus_q[b].pop_front();
                        chk($sformatf("bus%0d_beat", b), 64'(r[b*OPB*DW +: OPB*DW]), 64'(entry));
                    end
                end
            end
        end
    end

    initial begin
        reset_L    = 1'b0;
        wBusy      = 1'b0;
        wSelecLoad = 1'b0;
        wDataValid = 1'b0;
        wReady     = '1;
        wSelec     = '0;
        wData      = '0;
        wRegs      = '0;
        for (int k = 0; k < LANES; k++) begin
            new_org[k] = 0; new_idx[k] = 0; new_junk[k] = 0;
        end
        random_data();
        drive_vectors();
        model_reset();
        step();
        step();
        reset_L = 1'b1;
        step();

        // Reset table routes main input 0 to every lane
        main_in[0] = 10;
        drive_vectors();
        wDataValid = 1'b1;
        wReady     = 4'hF;
        step();
        wDataValid = 1'b0;
        step();

        // Load a mixed-origin table, then capture with it
        for (int k = 0; k < LANES; k++) begin
            new_org[k] = 0; new_idx[k] = 0; new_junk[k] = int'($urandom_range(0, 63));
        end
        new_idx[0]  = 5;
        new_org[15] = 1;
        new_idx[15] = 63;
        drive_vectors();
        wSelecLoad = 1'b1;
        step();
        wSelecLoad  = 1'b0;
        main_in[5]  = 3;
        regs_in[63] = 12;
        drive_vectors();
        wDataValid = 1'b1;
        step();
        wDataValid = 1'b0;
        step();

        // Backpressure on bus 2 stalls capture; releasing it admits the next beat at once
        random_table();
        drive_vectors();
        wSelecLoad = 1'b1;
        step();
        wSelecLoad = 1'b0;
        wDataValid = 1'b1;
        random_data(); drive_vectors();
        step();
        wReady = 4'b1011;
        for (int i = 0; i < 3; i++) begin
            random_data(); drive_vectors();
            step();
        end
        wReady = 4'hF;
        step();
        wDataValid = 1'b0;
        step();

        // Busy blocks capture but downstream still drains
        wDataValid = 1'b1;
        random_data(); drive_vectors();
        step();
        wBusy = 1'b1;
        for (int i = 0; i < 5; i++) begin
            random_data(); drive_vectors();
            wReady = NO'($urandom_range(0, 15));
            step();
        end
        wBusy      = 1'b0;
        wDataValid = 1'b0;
        wReady     = 4'hF;
        step();

        // Out-of-range main index on lane 3, then a plain load clears the flag
        for (int k = 0; k < LANES; k++) begin
            new_org[k] = 0; new_idx[k] = k % MI; new_junk[k] = 0;
        end
        new_idx[3] = 13;
        drive_vectors();
        wSelecLoad = 1'b1;
        step();
        wSelecLoad = 1'b0;
        wDataValid = 1'b1;
        random_data(); drive_vectors();
        step();
        wDataValid = 1'b0;
        step();
        new_idx[3] = 3;
        drive_vectors();
        wSelecLoad = 1'b1;
        step();
        wSelecLoad = 1'b0;
        step();

        // Load colliding with an accept captures through the previous table
        random_table();
        random_data();
        drive_vectors();
        wSelecLoad = 1'b1;
        wDataValid = 1'b1;
        step();
        wSelecLoad = 1'b0;
        wDataValid = 1'b0;
        step();

        // Run well past counter wrap at full throughput
        wDataValid = 1'b1;
        for (int i = 0; i < 20; i++) begin
            random_data(); drive_vectors();
            step();
        end
        wDataValid = 1'b0;
        step();

        // Randomized traffic, with occasional asynchronous reset mid-operation
        for (int i = 0; i < 3000; i++) begin
            random_data();
            if ($urandom_range(0, 19) == 0) random_table();
            drive_vectors();
            wSelecLoad = ($urandom_range(0, 19) == 0);
            wDataValid = ($urandom_range(0, 9) < 7);
            wBusy      = ($urandom_range(0, 9) < 2);
            for (int b = 0; b < NO; b++) wReady[b] = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 499) == 0) begin
                reset_L = 1'b0;
                model_reset();
                step();
                reset_L = 1'b1;
            end else begin
                step();
            end
        end

        wSelecLoad = 1'b0;
        wDataValid = 1'b0;
        wBusy      = 1'b0;
        wReady     = 4'hF;
        step();
        step();
        @(posedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
